// File: rtl/alpaca_dtypes_pkg.sv
// Shared sample type and frame-length defaults for the playback datapath.
package alpaca_dtypes_pkg;

  // One complex sample: signed 16-bit real and imaginary parts.
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cx_t;

  localparam int CX_W             = $bits(cx_t);
  localparam int DEF_SAMP_PER_CLK = 2;
  localparam int DEF_FFT_LEN      = 64;

  // Number of stream beats that make up one FFT frame.
  function automatic int frame_beats(input int fft_len, input int samp_per_clk);
    return fft_len / samp_per_clk;
  endfunction

endpackage

// File: rtl/alpaca_data_pkt_axis.sv
// AXI-stream style packet bus carrying N samples of type dtype per beat.
interface alpaca_data_pkt_axis #(
  parameter type dtype   = logic [31:0],
  parameter int  N       = 2,
  parameter int  TUSER_W = 1
);
  logic               tvalid;
  logic               tready;
  dtype [N-1:0]       tdata;
  logic               tlast;
  logic [TUSER_W-1:0] tuser;

  modport MST (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport SLV (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/playback_bram.sv
// Simple dual-port buffer: one write port, one registered read port (1-cycle latency).
module playback_bram #(
  parameter int DW    = 64,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Write port; contents have no reset so they survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/parallel_axis_playback.sv
// Plays a preloaded buffer out as whole frames on an AXI-stream master.
//
// Handshake: a beat transfers on a clock edge where tvalid and tready are both
// high. Once tvalid rises it stays high, and tdata/tlast/tuser hold, until that
// transfer happens. tvalid never depends combinationally on tready.
module parallel_axis_playback
  import alpaca_dtypes_pkg::*;
#(
  parameter int SAMP_PER_CLK = DEF_SAMP_PER_CLK,
  parameter int FFT_LEN      = DEF_FFT_LEN,
  parameter int DEPTH        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  cx_t  [SAMP_PER_CLK-1:0]  wr_data,
  input  logic                     start,
  input  logic                     loop,
  input  logic                     stop,
  alpaca_data_pkt_axis.MST         m_axis,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              frame_cnt,
  output logic [1:0]               dbg_state
);
  localparam int            AW        = $clog2(DEPTH);
  localparam int            DW        = SAMP_PER_CLK * CX_W;
  localparam int            BEATS     = frame_beats(FFT_LEN, SAMP_PER_CLK);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One skid entry: data plus framing flags; wrap marks the beat at LAST_ADDR.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    logic          wrap;
  } beat_t;

  state_t        state;
  logic [AW-1:0] rd_ptr;
  logic          rd_more;
  logic          loop_q;
  logic          stop_q;

  // Read in flight: rd_vld says the BRAM output holds a beat this cycle.
  logic          rd_vld;
  logic          rd_last, rd_user, rd_wrap;
  logic [DW-1:0] rd_data;

  // Two-entry skid/prefetch stage; q0 is the head driven onto the bus.
  logic [1:0]    cnt;
  beat_t         q0, q1;
  beat_t         landing;

  logic          head_vld, pop, issue, bram_re;
  logic [AW-1:0] bram_raddr;
  logic [2:0]    occ;
  logic [DW-1:0] wr_word;
  int            rd_pos;

  assign wr_word = wr_data;
  assign landing = {rd_data, rd_last, rd_user, rd_wrap};

  // Read issue: keep skid + in-flight occupancy at most two so no beat is lost.
  always_comb begin
    head_vld   = (cnt != 2'd0);
    pop        = head_vld & m_axis.tready;
    occ        = 3'(cnt) + 3'(rd_vld) - 3'(pop);
    issue      = (state == PLAY) && rd_more && (occ < 3'd2);
    bram_re    = ((state == IDLE) && start) || issue;
    bram_raddr = (state == IDLE) ? '0 : rd_ptr;
    rd_pos     = int'(bram_raddr) % BEATS;
  end

  playback_bram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_bram (
    .clk   (clk),
    .we    (wr_en && (state == IDLE)),
    .waddr (wr_addr),
    .wdata (wr_word),
    .re    (bram_re),
    .raddr (bram_raddr),
    .rdata (rd_data)
  );

  // Framing flags travel alongside the read so they line up with rd_data.
  always_ff @(posedge clk) begin
    if (bram_re) begin
      rd_last <= (rd_pos == BEATS - 1);
      rd_user <= (rd_pos == 0);
      rd_wrap <= (bram_raddr == LAST_ADDR);
    end
  end

  // Skid data: shift on pop, land the arriving read in the first free slot.
  always_ff @(posedge clk) begin
    if (rd_vld) begin
      if ((cnt == 2'd0) || ((cnt == 2'd1) && pop)) begin
        q0 <= landing;
      end else if (cnt == 2'd1) begin
        q1 <= landing;
      end else if (pop) begin
        q0 <= q1;
        q1 <= landing;
      end
    end else if (pop) begin
      q0 <= q1;
    end
  end

  // Control FSM: sequencing, occupancy, stop/loop latches, frame count, done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      rd_vld    <= 1'b0;
      rd_ptr    <= '0;
      rd_more   <= 1'b0;
      loop_q    <= 1'b0;
      stop_q    <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      done   <= 1'b0;
      rd_vld <= bram_re;
      unique case (state)
        IDLE: begin
          cnt <= 2'd0;
          if (start) begin
            state     <= PLAY;
            frame_cnt <= '0;
            loop_q    <= loop;
            stop_q    <= 1'b0;
            rd_ptr    <= (LAST_ADDR == '0) ? '0 : AW'(1);
            rd_more   <= (LAST_ADDR != '0) || loop;
          end
        end
        PLAY: begin
          cnt <= cnt + 2'(rd_vld) - 2'(pop);
          if (stop) stop_q <= 1'b1;
          if (issue) begin
            if (rd_ptr == LAST_ADDR) begin
              rd_ptr  <= '0;
              rd_more <= loop_q;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
          // Playback only ever ends on an accepted tlast, so frames stay whole.
          if (pop && q0.last) begin
            if (frame_cnt != '1) frame_cnt <= frame_cnt + 32'd1;
            if (stop_q || stop || (q0.wrap && !loop_q)) begin
              state  <= DRAIN;
              done   <= 1'b1;
              cnt    <= 2'd0;
              rd_vld <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state <= IDLE;
          cnt   <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = head_vld;
  assign m_axis.tdata  = q0.data;
  assign m_axis.tlast  = head_vld & q0.last;
  assign m_axis.tuser  = {head_vld & q0.user};
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_parallel_axis_playback.sv
// Directed bench for parallel_axis_playback with a ramp-loaded buffer.
`timescale 1ns/1ps
module tb_parallel_axis_playback;
  import alpaca_dtypes_pkg::*;

  localparam int SPC   = 2;
  localparam int FFT   = 64;
  localparam int DEPTH = 32;
  localparam int BEATS = FFT / SPC;
  localparam int AW    = 5;
  localparam int W     = 64;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst, wr_en, start, loop, stop, busy, done;
  logic [AW-1:0]    wr_addr;
  cx_t  [SPC-1:0]   wr_data;
  logic [31:0]      frame_cnt;
  logic [1:0]       dbg_state;

  alpaca_data_pkt_axis #(.dtype(cx_t), .N(SPC), .TUSER_W(1)) m_axis_if ();

  parallel_axis_playback #(
    .SAMP_PER_CLK (SPC),
    .FFT_LEN      (FFT),
    .DEPTH        (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .loop      (loop),
    .stop      (stop),
    .m_axis    (m_axis_if),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_q[$];
  bit            got_last_q[$];
  bit            got_user_q[$];
  int            got_cyc_q[$];
  int            done_cnt;
  int            first_valid_cyc;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ramp content: beat k carries k in every 16-bit lane.
  function automatic logic [W-1:0] beat_word(input int k);
    return 64'(k) * 64'h0001_0001_0001_0001;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_ramp();
    @(posedge clk); #1;
    for (int k = 0; k < DEPTH; k++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(k);
      wr_data = beat_word(k);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  // Start a playback at cycle 0 and capture accepted beats until done (+2 cycles)
  // or until max_cyc expires.
  task automatic run_play(input int pct, input bit loop_v, input int stop_cyc,
                          input bit stop_on_last, input int poke_cyc, input int max_cyc);
    logic [W-1:0] hold_d;
    bit           hold_v, hold_l, hold_u, stop_sent;
    int           post;
    got_q.delete(); got_last_q.delete(); got_user_q.delete(); got_cyc_q.delete();
    done_cnt = 0; first_valid_cyc = -1;
    hold_v = 1'b0; hold_d = '0; hold_l = 1'b0; hold_u = 1'b0; stop_sent = 1'b0; post = -1;
    @(posedge clk); #1;
    loop = loop_v;
    for (int n = 0; n < max_cyc; n++) begin
      start = (n == 0) || (n == poke_cyc);
      wr_en = (n == poke_cyc);
      if (n == poke_cyc) begin
        wr_addr = 5'd20;
        wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      stop = (n == stop_cyc);
      m_axis_if.tready = ($urandom_range(99) < pct);
      @(negedge clk);
      if (n == poke_cyc) check("poke_busy", 64'(busy), 64'd1);
      if (hold_v) begin
        check("stall_valid", 64'(m_axis_if.tvalid), 64'd1);
        check("stall_data", m_axis_if.tdata, hold_d);
        check("stall_flags", {62'd0, m_axis_if.tlast, m_axis_if.tuser[0]}, {62'd0, hold_l, hold_u});
        hold_v = 1'b0;
      end
      if (m_axis_if.tvalid) begin
        if (first_valid_cyc < 0) first_valid_cyc = n;
        if (m_axis_if.tready) begin
          got_q.push_back(m_axis_if.tdata);
          got_last_q.push_back(m_axis_if.tlast);
          got_user_q.push_back(m_axis_if.tuser[0]);
          got_cyc_q.push_back(n);
          if (stop_on_last && m_axis_if.tlast && !stop_sent) begin
            stop      = 1'b1;
            stop_sent = 1'b1;
          end
        end else begin
          hold_v = 1'b1;
          hold_d = m_axis_if.tdata;
          hold_l = m_axis_if.tlast;
          hold_u = m_axis_if.tuser[0];
        end
      end
      if (done) begin
        done_cnt++;
        if (post < 0) post = n;
      end
      if (post >= 0 && n >= post + 2) break;
      @(posedge clk); #1;
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0; loop = 1'b0;
    m_axis_if.tready = 1'b0;
  endtask

  // Compare captured beats against the ramp expectation.
  task automatic score_run(input string tag, input int exp_beats, input int exp_frames);
    logic [W-1:0] e;
    int           n_last;
    exp_q.delete();
    for (int k = 0; k < exp_beats; k++) exp_q.push_back(beat_word(k % DEPTH));
    check({tag, " beats"}, 64'(got_q.size()), 64'(exp_beats));
    n_last = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      check({tag, " data"}, got_q[i], e);
      check({tag, " tlast"}, 64'(got_last_q[i]), 64'((i % BEATS) == BEATS - 1));
      check({tag, " tuser"}, 64'(got_user_q[i]), 64'((i % BEATS) == 0));
      if (got_last_q[i]) n_last++;
    end
    check({tag, " frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
    check({tag, " frame_cnt_vs_tlast"}, 64'(frame_cnt), 64'(n_last));
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_gapless(input string tag);
    int gaps;
    gaps = 0;
    for (int i = 0; i < got_cyc_q.size(); i++)
      if (got_cyc_q[i] != 2 + i) gaps++;
    check({tag, " bubbles"}, 64'(gaps), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " tvalid"}, 64'(m_axis_if.tvalid), 64'd0);
    check({tag, " tlast"}, 64'(m_axis_if.tlast), 64'd0);
    check({tag, " tuser"}, 64'(m_axis_if.tuser[0]), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " frame_cnt"}, 64'(frame_cnt), 64'd0);
    check({tag, " state"}, 64'(dbg_state), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    bit rst_hit;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; loop = 1'b0; stop = 1'b0; m_axis_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    load_ramp();

    // Full ramp, always ready: 32 gapless beats, first one two cycles after start.
    run_play(100, 1'b0, -1, 1'b0, -1, 200);
    score_run("ramp", 32, 1);
    check("ramp first_valid_cycle", 64'(first_valid_cyc), 64'd2);
    check_gapless("ramp");

    // Same content under ~50% backpressure.
    run_play(50, 1'b0, -1, 1'b0, -1, 800);
    score_run("stall", 32, 1);

    // Looping with stop at cycle 50 (beat 48): runs to the end of frame 2.
    run_play(100, 1'b1, 50, 1'b0, -1, 300);
    score_run("loop_stop", 64, 2);
    check_gapless("loop_stop");

    // Looping with stop on the same cycle as the first tlast accept.
    run_play(100, 1'b1, -1, 1'b1, -1, 300);
    score_run("stop_on_last", 32, 1);

    // start and wr_en (addr 20) while busy must have no effect.
    run_play(100, 1'b0, -1, 1'b0, 6, 200);
    score_run("busy_poke", 32, 1);

    // Reset during beat 10 of a playback.
    seen = 0; rst_hit = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; loop = 1'b0; m_axis_if.tready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_axis_if.tvalid && m_axis_if.tready) begin
        if (seen == 10) begin
          check("rst beat10 data", m_axis_if.tdata, beat_word(10));
          rst = 1'b1;
          rst_hit = 1'b1;
          break;
        end
        seen++;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("rst reached beat10", 64'(rst_hit), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; m_axis_if.tready = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    @(negedge clk);
    check("mid_rst still_idle", 64'(m_axis_if.tvalid), 64'd0);

    // Replay after reset: buffer contents intact, restart from beat 0.
    run_play(100, 1'b0, -1, 1'b0, -1, 200);
    score_run("after_rst", 32, 1);
    check_gapless("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parallel_axis_playback.md
PARALLEL_AXIS_PLAYBACK -- requirements
Module: parallel_axis_playback

Interface
REQ-001 The module SHALL have parameter SAMP_PER_CLK, default 2, meaning samples per AXIS beat.
REQ-002 The module SHALL have parameter FFT_LEN, default 64, meaning samples per frame; frame length is FFT_LEN/SAMP_PER_CLK beats.
REQ-003 The module SHALL have parameter DEPTH, default 32, meaning buffer depth in beats, an integer multiple of FFT_LEN/SAMP_PER_CLK.
REQ-004 The module SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-005 The module SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 The module SHALL have port wr_en, input, 1, meaning buffer write strobe, accepted only in IDLE.
REQ-007 The module SHALL have port wr_addr, input, $clog2(DEPTH), meaning buffer write beat address.
REQ-008 The module SHALL have port wr_data, input, SAMP_PER_CLK x cx_t, meaning one beat of samples.
REQ-009 The module SHALL have port start, input, 1, meaning a one-cycle playback request, honoured only in IDLE.
REQ-010 The module SHALL have port loop, input, 1, meaning restart at address 0 after the last beat; sampled at start.
REQ-011 The module SHALL have port stop, input, 1, meaning end playback after the current frame's tlast beat is accepted.
REQ-012 The module SHALL have port m_axis, alpaca_data_pkt_axis.MST (dtype cx_t, TUSER 1), meaning the playback stream.
REQ-013 The module SHALL have port busy, output, 1, meaning state is not IDLE.
REQ-014 The module SHALL have port done, output, 1, meaning a one-cycle pulse when playback ends.
REQ-015 The module SHALL have port frame_cnt, output, 32, meaning frames fully transferred since the last start.

Function
REQ-016 The FSM SHALL have states IDLE, PLAY and DRAIN.
REQ-017 IDLE to PLAY SHALL occur on start; frame_cnt SHALL clear and the read address SHALL be 0.
REQ-018 The buffer SHALL have a one-cycle registered read; the first beat SHALL be presented with m_axis.tvalid=1 exactly two cycles after start.
REQ-019 A beat SHALL transfer only when tvalid and tready are both high; tdata, tlast and tuser SHALL stay stable while tvalid=1 and tready=0.
REQ-020 Under continuous tready=1 the output SHALL sustain one beat per cycle with no bubbles, using a two-entry skid/prefetch stage.
REQ-021 m_axis.tlast SHALL be 1 on each beat at offset FFT_LEN/SAMP_PER_CLK-1 within a frame; m_axis.tuser[0] SHALL be 1 on offset 0.
REQ-022 frame_cnt SHALL increment on each accepted tlast beat and saturate at 2^32-1.
REQ-023 After the beat at address DEPTH-1 is accepted, playback SHALL wrap to address 0 if loop was set and stop is not pending; otherwise it SHALL enter DRAIN.
REQ-024 A pending stop, or stop asserted on the same cycle as a tlast accept, SHALL enter DRAIN after that tlast; no partial frame SHALL ever be emitted.
REQ-025 DRAIN SHALL deassert tvalid, discard prefetched beats, pulse done for one cycle, and return to IDLE on the next cycle.
REQ-026 wr_en in PLAY or DRAIN SHALL be ignored, and start outside IDLE SHALL be ignored.

Reset
REQ-027 rst SHALL force IDLE, tvalid=0, tlast=0, tuser=0, busy=0, done=0, frame_cnt=0, clear the stop and loop latches, and empty the skid stage; buffer contents SHALL be preserved.
REQ-028 rst mid-PLAY SHALL take effect on the next edge with no further beat transferred.

Structure
REQ-029 cx_t and the frame-length constants SHALL come from alpaca_dtypes_pkg; the FSM state enum SHALL be local to the module.
REQ-030 The storage SHALL be a single sub-module, playback_bram (simple dual-port, 1-cycle read), inferable as block RAM.

Verification
REQ-031 Load a ramp (beat k = k) for DEPTH=32, FFT_LEN=64, SAMP_PER_CLK=2, loop=0, start with tready=1: the bench SHALL see beats 0..31 on consecutive cycles, tlast on beat 31, tuser on beat 0, frame_cnt=1 and one done pulse.
REQ-032 Repeat with random 50% tready: the bench SHALL see the identical beat sequence with stable data during stalls.
REQ-033 Run with loop=1 and stop at cycle 50: the bench SHALL see whole frames only, ending on a tlast, with frame_cnt equal to the number of tlast beats seen.
REQ-034 Assert rst during beat 10 of PLAY: the bench SHALL see tvalid=0 on the next cycle, then a new start SHALL replay from beat 0 with contents intact.
REQ-035 Assert start and wr_en while busy: the bench SHALL see no restart and no buffer change.
REQ-036 Assert stop on the same cycle as the tlast accept: the bench SHALL see playback end immediately with no extra frame.
